// File: rtl/sga_dir_pkg.sv
// Shared direction codes, FSM encodings and helpers for the snake direction input stage.
package sga_dir_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_RUN    = 4'b0001,
    ST_PAUSED = 4'b0010
  } state_e;

  localparam int NUM_BTNS = 4;

  // Flipping the axis-sign bit gives the 180-degree reversal.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, consecutive-cycle debounce counter, stable level
// and a single-cycle press pulse on its rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic restart,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the stable one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/direction_input.sv
// Button conditioning and direction queue for the snake game. Define DIR_QUEUE_EN for a
// QUEUE_DEPTH-entry FIFO; otherwise a single latest-wins pending slot is used.
module direction_input
  import sga_dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic       clock,
  input  logic       restart,
  input  logic [3:0] buttons,
  input  logic       enable,
  input  logic       pause,
  input  logic       move_tick,
  output logic [1:0] direction,
  output logic       pending,
  output logic [1:0] db_queue_count,
  output logic [3:0] db_state
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_BTNS-1:0] press;
  logic                req_vld, legal, active, flush, go_run, push, pop;
  dir_e                req_dir, ref_dir;
  dir_e                dir_q, dir_d;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .restart(restart),
      .btn_raw(buttons[b]),
      .press  (press[b])
    );
  end

  // Lowest button index wins when several presses land together.
  always_comb begin
    req_vld = 1'b0;
    req_dir = DIR_RIGHT;
    for (int b = NUM_BTNS - 1; b >= 0; b--) begin
      if (press[b]) begin
        req_vld = 1'b1;
        req_dir = dir_e'(2'(b));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    go_run  = 1'b0;
    case (state_q)
      ST_IDLE: if (enable) begin
        state_d = ST_RUN;
        flush   = 1'b1;
        go_run  = 1'b1;
      end
      ST_RUN: if (!enable) begin
        state_d = ST_IDLE;
        flush   = 1'b1;
      end else if (pause) state_d = ST_PAUSED;
      ST_PAUSED: if (!enable) begin
        state_d = ST_IDLE;
        flush   = 1'b1;
      end else if (!pause) state_d = ST_RUN;
      default: begin
        state_d = ST_IDLE;
        flush   = 1'b1;
      end
    endcase
  end

  // Leaving RUN for IDLE suppresses this cycle's push/pop so the held direction survives.
  assign active = (state_q == ST_RUN) && enable;
  assign legal  = (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
  assign pop    = active && move_tick && (cnt_q != '0);

`ifdef DIR_QUEUE_EN
  localparam int PW = $clog2(QUEUE_DEPTH);

  dir_e          mem_q [QUEUE_DEPTH];
  dir_e          mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, tail_idx;
  logic          full;

  assign tail_idx = wr_q - 1'b1;
  assign ref_dir  = (cnt_q != '0) ? mem_q[tail_idx] : dir_q;
  assign full     = (cnt_q == CW'(QUEUE_DEPTH));
  assign push     = active && req_vld && legal && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (pop) begin
      dir_d = mem_q[rd_q];
      rd_d  = rd_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_q] = req_dir;
      wr_d        = wr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
    if (go_run) dir_d = DIR_RIGHT;
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= DIR_RIGHT;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end
`else
  dir_e slot_q, slot_d;

  assign ref_dir = dir_q;
  assign push    = active && req_vld && legal;

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    if (pop) begin
      dir_d = slot_q;
      cnt_d = '0;
    end
    if (push) begin
      slot_d = req_dir;
      cnt_d  = CW'(1);
    end
    if (flush)  cnt_d = '0;
    if (go_run) dir_d = DIR_RIGHT;
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) slot_q <= DIR_RIGHT;
    else         slot_q <= slot_d;
  end
`endif

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_RIGHT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign direction      = dir_q;
  assign pending        = (cnt_q != '0);
  assign db_queue_count = 2'(cnt_q);
  assign db_state       = state_q;

endmodule
